// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: decode handshake, execute redirect and the byte-wide memory read port.
// The fetch unit uses the slave view; the surrounding pipeline/memory uses the master view.
interface if_fetch_if;
    logic        stall_in;
    logic        branch_we_in;
    logic [31:0] branch_addr_in;
    logic        mem_re_out;
    logic [31:0] mem_addr_out;
    logic [7:0]  mem_data_in;
    logic        mem_ack_in;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        rec_out;

    modport slave (
        input  stall_in,
        input  branch_we_in,
        input  branch_addr_in,
        input  mem_data_in,
        input  mem_ack_in,
        output mem_re_out,
        output mem_addr_out,
        output pc_out,
        output inst_out,
        output rec_out
    );

    modport master (
        output stall_in,
        output branch_we_in,
        output branch_addr_in,
        output mem_data_in,
        output mem_ack_in,
        input  mem_re_out,
        input  mem_addr_out,
        input  pc_out,
        input  inst_out,
        input  rec_out
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch with a direct-mapped I-cache; misses are filled from four byte reads.
// Presents registered pc/inst to decode, holds on stall, redirects on branch from execute.
module if_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned ICACHE_LINES = 64
) (
    input  logic       clk_in,
    input  logic       rst_in,
    if_fetch_if.slave  bus
);
    localparam int unsigned IDX  = $clog2(ICACHE_LINES);
    localparam int unsigned TAGW = 30 - IDX;

    typedef enum logic [1:0] {StLookup, StMem} state_e;

    state_e                  state_q;
    logic [31:0]             pc_q;
    logic [1:0]              k_q;
    logic [23:0]             buf_q;
    logic [ICACHE_LINES-1:0] valid_q;
    logic [TAGW-1:0]         tag_q  [ICACHE_LINES];
    logic [31:0]             data_q [ICACHE_LINES];
    logic                    mem_re_q;
    logic [31:0]             mem_addr_q;
    logic [31:0]             pc_out_q;
    logic [31:0]             inst_out_q;
    logic                    rec_q;

    logic [IDX-1:0]  idx;
    logic [TAGW-1:0] tag;
    logic            hit;
    logic            fill_we;
    logic [1:0]      k_d;
    logic [31:0]     fill_word_d;

    assign idx         = pc_q[IDX+1:2];
    assign tag         = pc_q[31:IDX+2];
    assign hit         = valid_q[idx] && (tag_q[idx] == tag);
    assign k_d         = k_q + 2'd1;
    assign fill_word_d = {bus.mem_data_in, buf_q};
    // Redirect on the final ack cancels the line write.
    assign fill_we     = (state_q == StMem) && bus.mem_ack_in && (k_q == 2'd3)
                         && !bus.branch_we_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= StLookup;
            pc_q       <= RESET_PC;
            k_q        <= 2'd0;
            buf_q      <= 24'd0;
            valid_q    <= '0;
            mem_re_q   <= 1'b0;
            mem_addr_q <= 32'd0;
            pc_out_q   <= 32'd0;
            inst_out_q <= 32'd0;
            rec_q      <= 1'b0;
        end else if (bus.branch_we_in) begin
            pc_q     <= bus.branch_addr_in;
            rec_q    <= 1'b0;
            state_q  <= StLookup;
            k_q      <= 2'd0;
            mem_re_q <= 1'b0;
        end else begin
            unique case (state_q)
                StLookup: begin
                    if (!bus.stall_in) begin
                        if (hit) begin
                            pc_out_q   <= pc_q;
                            inst_out_q <= data_q[idx];
                            rec_q      <= 1'b1;
                            pc_q       <= pc_q + 32'd4;
                        end else begin
                            rec_q      <= 1'b0;
                            k_q        <= 2'd0;
                            state_q    <= StMem;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= pc_q;
                        end
                    end
                end
                StMem: begin
                    if (bus.mem_ack_in) begin
                        case (k_q)
                            2'd0:    buf_q[7:0]   <= bus.mem_data_in;
                            2'd1:    buf_q[15:8]  <= bus.mem_data_in;
                            2'd2:    buf_q[23:16] <= bus.mem_data_in;
                            default: ;
                        endcase
                        k_q <= k_d;
                        if (k_q == 2'd3) begin
                            valid_q[idx] <= 1'b1;
                            state_q      <= StLookup;
                            mem_re_q     <= 1'b0;
                        end else begin
                            mem_addr_q <= pc_q + {30'd0, k_d};
                        end
                    end
                end
                default: state_q <= StLookup;
            endcase
        end
    end

    // Tag/data need no reset: valid bits gate every use.
    always_ff @(posedge clk_in) begin
        if (fill_we) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= fill_word_d;
        end
    end

    assign bus.mem_re_out   = mem_re_q;
    assign bus.mem_addr_out = mem_addr_q;
    assign bus.pc_out       = pc_out_q;
    assign bus.inst_out     = inst_out_q;
    assign bus.rec_out      = rec_q;
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage feeding the decode stage through a registered IF/ID boundary. It keeps the fetch PC and looks instructions up in a direct-mapped instruction cache. On a miss it assembles the 32-bit instruction from four byte reads on the memory-controller port. It presents `pc_out`/`inst_out` with a valid flag, holds them while decode blocks, and redirects on a taken branch/jump from execute.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `ICACHE_LINES`, 64, cache entries; power of two, ≥2; `IDX = log2(ICACHE_LINES)`
- `clk_in`  input  1  clock
- `rst_in`  input  1  reset; asynchronous, active-high
- `stall_in`  input  1  decode blocked (decode `blk_out`); current output not consumed
- `branch_we_in`  input  1  redirect request from execute
- `branch_addr_in`  input  32  redirect target (word-aligned)
- `mem_re_out`  output  1  byte read request to memory controller
- `mem_addr_out`  output  32  byte address of request
- `mem_data_in`  input  8  read byte, valid when `mem_ack_in`=1
- `mem_ack_in`  input  1  request accepted; `mem_data_in` valid this cycle
- `pc_out`  output  32  PC of presented instruction
- `inst_out`  output  32  presented instruction
- `rec_out`  output  1  `pc_out`/`inst_out` valid (decode `rec_in`)

## Operation
- Internal: `pc` (next fetch address), 2-bit state {LOOKUP, MEM}, 2-bit byte counter `k`, 24-bit byte buffer, and a cache of `ICACHE_LINES` × {valid, tag[31:IDX+2], data[31:0]}.
- Index = `pc[IDX+1:2]`; tag = `pc[31:IDX+2]`; hit = valid & tag match, evaluated combinationally in LOOKUP.
- LOOKUP, `stall_in`=0, hit: register `pc_out`←pc, `inst_out`←data, `rec_out`←1, pc←pc+4 (32-bit wrap). Stay in LOOKUP.
- LOOKUP, `stall_in`=0, miss: `rec_out`←0, k←0, go to MEM.
- LOOKUP, `stall_in`=1: all outputs and pc hold; no lookup, no memory request.
- MEM: `mem_re_out`=1, `mem_addr_out`=pc+k, both held stable until `mem_ack_in`. On ack, byte k is captured (little-endian: byte 0 → bits 7:0) and k increments. On the ack with k=3, the line is written (valid←1, tag, {mem_data_in, buffer}) and the state returns to LOOKUP. The next lookup hits and presents the instruction.
- In MEM, `stall_in` is ignored for the fill. `rec_out` and the held outputs are unchanged until the fill returns to LOOKUP.
- `branch_we_in`=1 in any state has highest priority: pc←`branch_addr_in`, `rec_out`←0, state←LOOKUP, k←0, `mem_re_out` drops next cycle, partial bytes are discarded, and there is no cache write. A simultaneous `mem_ack_in` is ignored.
- The cache is never invalidated except by reset; there is no self-modifying-code support.

## Timing
- Reset (async, immediate): pc=`RESET_PC`, state=LOOKUP, k=0, all valid bits 0, `pc_out`=0, `inst_out`=0, `rec_out`=0, `mem_re_out`=0, `mem_addr_out`=0.
- Hit latency: 1 cycle from lookup to registered output. Back-to-back hits give one instruction per cycle.
- Miss latency: 1 lookup cycle + 4 acked byte cycles (minimum 4 if acks are immediate) + 1 re-lookup cycle. Minimum 6 cycles from the miss lookup to `rec_out`=1.
- `mem_re_out` and `mem_addr_out` are registered. The address advances in the cycle after each ack. `mem_re_out` stays high across consecutive bytes of one fill.
- Decode consumes when `rec_out`=1 and `stall_in`=0. The output registers change only on that condition, on a miss (`rec_out`→0), or on a redirect.
- Redirect: `rec_out`=0 the cycle after `branch_we_in`. The earliest valid target instruction comes one cycle after that, on a hit.
- Reset mid-fill discards the fill. Reset asserted with `mem_ack_in` high writes no cache entry.

## Test plan
- Reset, RESET_PC=0, memory holds 0x00500093 at 0 (bytes 93,00,50,00), ack every cycle → reads at addresses 0,1,2,3; `rec_out`=1, `pc_out`=0, `inst_out`=0x00500093 six cycles after reset release.
- Loop of 4 instructions at 0x0 to 0xC with branch back to 0x0 → second pass gives `mem_re_out`=0 throughout and one `rec_out` per cycle with pc 0,4,8,C.
- `stall_in` held 3 cycles while `rec_out`=1, `pc_out`=0x8 → outputs unchanged for 3 cycles; pc 0xC presented the cycle after release (hit).
- `branch_we_in` with target 0x40 during byte k=2 of fill at 0x10 → `mem_re_out` drops, no line written for 0x10, next request address 0x40.
- Acks delayed 3 cycles per byte → `mem_addr_out` stable during the wait; instruction correct after 4 acks.
- `ICACHE_LINES`=64, fetch 0x000 then 0x100 (same index) then 0x000 → three misses; data correct each time.
